// File: rtl/flag_pkg.sv
// Shared constants for the flag context unit: flag bit positions and
// default sizing for the live flag register and its save stack.
package flag_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam int NFLAGS_DEFAULT = 4;
  localparam int DEPTH_DEFAULT  = 4;

endpackage

// File: rtl/flag_lifo.sv
// Small LIFO holding saved flag contexts. Storage is not reset; only the
// occupancy counter is, so stale entries can never be read back.
module flag_lifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  // A simultaneous push and pop is a no-op on the stack.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_idx = AW'(count);
  assign rd_idx = AW'(count - CW'(1));
  assign rdata  = mem[rd_idx];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

endmodule

// File: rtl/flag_context_unit.sv
// Live ALU flag register with per-bit write mask, sticky bits, and a
// push/pop context stack. All state advances on the falling clock edge.
module flag_context_unit
  import flag_pkg::*;
#(
  parameter int                NFLAGS      = NFLAGS_DEFAULT,
  parameter int                DEPTH       = DEPTH_DEFAULT,
  parameter logic [NFLAGS-1:0] STICKY_MASK = '0,
  parameter int                CW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              flag_write_en,
  input  logic [NFLAGS-1:0] write_mask,
  input  logic              clear_sticky,
  input  logic              push,
  input  logic              pop,
  input  logic              clear_err,
  output logic [NFLAGS-1:0] flags_out,
  output logic [CW-1:0]     depth_count,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [NFLAGS-1:0] rdata;
  logic [NFLAGS-1:0] wr_bits;
  logic [NFLAGS-1:0] plain_next;
  logic [NFLAGS-1:0] sticky_next;
  logic [NFLAGS-1:0] flags_next;
  logic              pop_restore;
  logic              ovf_event;
  logic              unf_event;

  // The stack captures flags_out as it stands before this edge's update.
  flag_lifo #(
    .W     (NFLAGS),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (flags_out),
    .rdata (rdata),
    .count (depth_count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign pop_restore = pop & ~push & ~stack_empty;
  assign ovf_event   = push & ~pop & stack_full;
  assign unf_event   = pop & ~push & stack_empty;

  // Sticky bits only ever set from a write; clearing loses to a coincident set.
  always_comb begin
    wr_bits     = {NFLAGS{flag_write_en}} & write_mask;
    plain_next  = (flags_out & ~wr_bits) | (flags_in & wr_bits);
    sticky_next = (clear_sticky ? '0 : flags_out) | (flags_in & wr_bits);
    flags_next  = (plain_next & ~STICKY_MASK) | (sticky_next & STICKY_MASK);
    if (pop_restore) begin
      flags_next = rdata;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_out     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      flags_out     <= flags_next;
      overflow_err  <= ovf_event | (overflow_err & ~clear_err);
      underflow_err <= unf_event | (underflow_err & ~clear_err);
    end
  end

endmodule

// File: tb/tb_flag_context_unit.sv
// Directed bench for flag_context_unit with V as the only sticky flag.
module tb_flag_context_unit;
  import flag_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] flags_in;
  logic       flag_write_en;
  logic [3:0] write_mask;
  logic       clear_sticky;
  logic       push;
  logic       pop;
  logic       clear_err;
  logic [3:0] flags_out;
  logic [2:0] depth_count;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow_err;
  logic       underflow_err;

  int checks = 0;
  int errors = 0;

  flag_context_unit #(
    .NFLAGS      (4),
    .DEPTH       (4),
    .STICKY_MASK (4'b0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flags_in      (flags_in),
    .flag_write_en (flag_write_en),
    .write_mask    (write_mask),
    .clear_sticky  (clear_sticky),
    .push          (push),
    .pop           (pop),
    .clear_err     (clear_err),
    .flags_out     (flags_out),
    .depth_count   (depth_count),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flags_in      = '0;
    flag_write_en = 1'b0;
    write_mask    = '0;
    clear_sticky  = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    clear_err     = 1'b0;
  endtask

  // Apply the currently driven inputs on the next falling edge, then settle.
  task automatic tick();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] val, input logic [3:0] mask);
    flags_in      = val;
    write_mask    = mask;
    flag_write_en = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_flags", 32'(flags_out), 32'h0);
    chk("rst_depth", 32'(depth_count), 32'h0);
    chk("rst_empty", 32'(stack_empty), 32'h1);
    chk("rst_full", 32'(stack_full), 32'h0);
    chk("rst_ovf", 32'(overflow_err), 32'h0);
    chk("rst_unf", 32'(underflow_err), 32'h0);
    @(posedge clk);
    rst_n = 1'b1;

    // Masked writes
    wr(4'b1010, 4'b1111); tick();
    chk("wr_full_mask", 32'(flags_out), 32'b1010);
    wr(4'b0001, 4'b0001); tick();
    chk("wr_bit0_mask", 32'(flags_out), 32'b1011);
    wr(4'b0000, 4'b0000); tick();
    chk("wr_no_mask", 32'(flags_out), 32'b1011);

    // Sticky V
    wr(4'b0100, 4'(1 << FLAG_V)); tick();
    chk("sticky_set", 32'(flags_out), 32'b1111);
    wr(4'b0000, 4'(1 << FLAG_V)); tick();
    chk("sticky_hold", 32'(flags_out), 32'b1111);
    clear_sticky = 1'b1; tick();
    chk("sticky_clear", 32'(flags_out), 32'b1011);
    wr(4'b0100, 4'b0100); clear_sticky = 1'b1; tick();
    chk("sticky_set_wins", 32'(flags_out), 32'b1111);
    clear_sticky = 1'b1; tick();
    chk("sticky_clear2", 32'(flags_out), 32'b1011);

    // Push with coincident write saves the pre-update value
    wr(4'b0011, 4'b1111); tick();
    chk("load_0011", 32'(flags_out), 32'b0011);
    wr(4'b1100, 4'b1111); push = 1'b1; tick();
    chk("push_wr_flags", 32'(flags_out), 32'b1100);
    chk("push_wr_depth", 32'(depth_count), 32'd1);
    wr(4'b1111, 4'b1111); clear_sticky = 1'b1; pop = 1'b1; tick();
    chk("pop_restore", 32'(flags_out), 32'b0011);
    chk("pop_depth", 32'(depth_count), 32'd0);
    chk("pop_empty", 32'(stack_empty), 32'h1);

    // Fill, overflow, drain in LIFO order, underflow
    wr(4'b0001, 4'b1111); tick(); push = 1'b1; tick();
    wr(4'b0010, 4'b1111); tick(); push = 1'b1; tick();
    wr(4'b1000, 4'b1111); tick(); push = 1'b1; tick();
    wr(4'b1001, 4'b1111); tick(); push = 1'b1; tick();
    chk("fill_depth", 32'(depth_count), 32'd4);
    chk("fill_full", 32'(stack_full), 32'h1);
    chk("fill_ovf_clear", 32'(overflow_err), 32'h0);
    wr(4'b0011, 4'b1111); tick(); push = 1'b1; tick();
    chk("ovf_depth", 32'(depth_count), 32'd4);
    chk("ovf_err", 32'(overflow_err), 32'h1);
    pop = 1'b1; tick();
    chk("lifo_pop1", 32'(flags_out), 32'b1001);
    chk("lifo_depth3", 32'(depth_count), 32'd3);
    pop = 1'b1; tick();
    chk("lifo_pop2", 32'(flags_out), 32'b1000);
    pop = 1'b1; tick();
    chk("lifo_pop3", 32'(flags_out), 32'b0010);
    pop = 1'b1; tick();
    chk("lifo_pop4", 32'(flags_out), 32'b0001);
    chk("lifo_empty", 32'(stack_empty), 32'h1);
    chk("unf_before", 32'(underflow_err), 32'h0);
    pop = 1'b1; tick();
    chk("unf_err", 32'(underflow_err), 32'h1);
    chk("unf_flags", 32'(flags_out), 32'b0001);
    chk("unf_depth", 32'(depth_count), 32'd0);

    // Push+pop together at depth 2
    push = 1'b1; tick(); push = 1'b1; tick();
    chk("pp_depth_pre", 32'(depth_count), 32'd2);
    wr(4'b0110, 4'b1111); push = 1'b1; pop = 1'b1; tick();
    chk("pp_depth", 32'(depth_count), 32'd2);
    chk("pp_flags", 32'(flags_out), 32'b0110);
    chk("pp_ovf_held", 32'(overflow_err), 32'h1);
    clear_err = 1'b1; tick();
    chk("clr_ovf", 32'(overflow_err), 32'h0);
    chk("clr_unf", 32'(underflow_err), 32'h0);

    // Error set beats coincident clear
    push = 1'b1; tick(); push = 1'b1; tick();
    chk("refill_full", 32'(stack_full), 32'h1);
    push = 1'b1; clear_err = 1'b1; tick();
    chk("err_set_wins", 32'(overflow_err), 32'h1);
    pop = 1'b1; tick();
    clear_err = 1'b1; tick();
    chk("depth3", 32'(depth_count), 32'd3);

    // Asynchronous reset mid-stack
    rst_n = 1'b0;
    #1;
    chk("arst_depth", 32'(depth_count), 32'd0);
    chk("arst_flags", 32'(flags_out), 32'h0);
    chk("arst_empty", 32'(stack_empty), 32'h1);
    @(posedge clk);
    rst_n = 1'b1;
    pop = 1'b1; tick();
    chk("arst_discard_unf", 32'(underflow_err), 32'h1);
    chk("arst_discard_flags", 32'(flags_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
